eeg_pea_eng_feed: RTL and testbench

Feeder that drives the DIN side of one PE in the engine PE array. On a start pulse it walks activation RAM addresses from a configured begin to end address. For each activation it issues one DIN beat per weight tap. ACT_DAT and ACT_ADD are held for the whole activation; WEI_DAT, WEI_IDX and WEI_LST step through the taps. A small weight register file, loaded while idle, supplies the weights. A one-deep prefetch stage hides the one-cycle activation RAM read latency.

---
 rtl/eeg_pea_eng_feed.sv | 175 +++++++++++++++++
 tb/tb_eeg_pea_eng_feed.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_pea_eng_feed.sv
// ============================================================================
// Module  : eeg_pea_eng_feed
// Brief   : DIN-side feeder for one engine PE: walks activation RAM and emits
//           one beat per weight tap, with a one-deep activation prefetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eeg_pea_eng_feed #(
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int ARAM_ADD_AW = 10,
  parameter int CONV_WEI_DW = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   IS_IDLE,
  input  logic                   CFG_START,
  input  logic [ARAM_ADD_AW-1:0] CFG_ACT_BEG,
  input  logic [ARAM_ADD_AW-1:0] CFG_ACT_END,
  input  logic [CONV_WEI_DW-1:0] CFG_CONV_WEI,
  input  logic                   WEI_WR_EN,
  input  logic [CONV_WEI_DW-1:0] WEI_WR_IDX,
  input  logic [DATA_WEI_DW-1:0] WEI_WR_DAT,
  output logic                   ARAM_RD_EN,
  output logic [ARAM_ADD_AW-1:0] ARAM_RD_ADD,
  input  logic [DATA_ACT_DW-1:0] ARAM_RD_DAT,
  output logic                   DIN_VLD,
  input  logic                   DIN_RDY,
  output logic                   ACT_LST,
  output logic                   WEI_LST,
  output logic [DATA_ACT_DW-1:0] ACT_DAT,
  output logic [ARAM_ADD_AW-1:0] ACT_ADD,
  output logic [DATA_WEI_DW-1:0] WEI_DAT,
  output logic [CONV_WEI_DW-1:0] WEI_IDX
);

  localparam int c_rf_depth = 2**CONV_WEI_DW;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FEED = 1'b1
  } state_t;

  state_t                 r_state;
  logic [ARAM_ADD_AW-1:0] r_beg_unused_guard;
  logic [ARAM_ADD_AW-1:0] r_end;
  logic [CONV_WEI_DW-1:0] r_wei;
  logic [ARAM_ADD_AW:0]   r_rd_ptr;
  logic [ARAM_ADD_AW-1:0] r_rd_add;
  logic                   r_rd_pend;
  logic                   r_nxt_vld;
  logic [DATA_ACT_DW-1:0] r_nxt_dat;
  logic [ARAM_ADD_AW-1:0] r_nxt_add;
  logic                   r_cur_vld;
  logic [DATA_ACT_DW-1:0] r_cur_dat;
  logic [ARAM_ADD_AW-1:0] r_cur_add;
  logic [CONV_WEI_DW-1:0] r_k;
  logic [DATA_WEI_DW-1:0] r_wei_rf [c_rf_depth];

  logic                   w_feed;
  logic                   w_accept;
  logic                   w_wei_lst;
  logic                   w_act_lst;
  logic                   w_cur_done;
  logic                   w_last_beat;
  logic                   w_nxt_avail;
  logic                   w_nxt_pop;
  logic                   w_rd_issue;
  logic                   w_start_ok;
  logic [DATA_ACT_DW-1:0] w_nxt_dat;
  logic [ARAM_ADD_AW-1:0] w_nxt_add;

  assign w_feed      = (r_state == ST_FEED);
  assign w_accept    = r_cur_vld & DIN_RDY;
  assign w_wei_lst   = (r_k == r_wei - 1'b1);
  assign w_act_lst   = (r_cur_add == r_end);
  assign w_cur_done  = w_accept & w_wei_lst;
  assign w_last_beat = w_cur_done & w_act_lst;

  // Read data arriving this cycle may be promoted straight into cur, so the
  // prefetch slot is treated as occupied while a read is pending.
  assign w_nxt_avail = r_nxt_vld | r_rd_pend;
  assign w_nxt_pop   = w_nxt_avail & (~r_cur_vld | w_cur_done);
  assign w_nxt_dat   = r_nxt_vld ? r_nxt_dat : ARAM_RD_DAT;
  assign w_nxt_add   = r_nxt_vld ? r_nxt_add : r_rd_add;

  assign w_rd_issue  = w_feed & (r_rd_ptr <= {1'b0, r_end}) & ~r_rd_pend
                     & (~r_nxt_vld | w_nxt_pop);
  assign w_start_ok  = ~w_feed & CFG_START & (CFG_CONV_WEI != '0)
                     & (CFG_ACT_BEG <= CFG_ACT_END);

  assign IS_IDLE     = ~w_feed;
  assign ARAM_RD_EN  = w_rd_issue;
  assign ARAM_RD_ADD = w_rd_issue ? r_rd_ptr[ARAM_ADD_AW-1:0] : '0;
  assign DIN_VLD     = r_cur_vld;
  assign ACT_LST     = r_cur_vld & w_act_lst;
  assign WEI_LST     = r_cur_vld & w_wei_lst;
  assign ACT_DAT     = r_cur_vld ? r_cur_dat : '0;
  assign ACT_ADD     = r_cur_vld ? r_cur_add : '0;
  assign WEI_DAT     = r_cur_vld ? r_wei_rf[r_k] : '0;
  assign WEI_IDX     = r_cur_vld ? r_k : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_rf_depth; i++) r_wei_rf[i] <= '0;
    end else if (~w_feed && WEI_WR_EN) begin
      r_wei_rf[WEI_WR_IDX] <= WEI_WR_DAT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= ST_IDLE;
      r_beg_unused_guard <= '0;
      r_end              <= '0;
      r_wei              <= '0;
      r_rd_ptr           <= '0;
      r_rd_add           <= '0;
      r_rd_pend          <= 1'b0;
      r_nxt_vld          <= 1'b0;
      r_nxt_dat          <= '0;
      r_nxt_add          <= '0;
      r_cur_vld          <= 1'b0;
      r_cur_dat          <= '0;
      r_cur_add          <= '0;
      r_k                <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_beg_unused_guard <= CFG_ACT_BEG;
            r_end              <= CFG_ACT_END;
            r_wei              <= CFG_CONV_WEI;
            r_rd_ptr           <= {1'b0, CFG_ACT_BEG};
            r_rd_pend          <= 1'b0;
            r_nxt_vld          <= 1'b0;
            r_cur_vld          <= 1'b0;
            r_k                <= '0;
            r_state            <= ST_FEED;
          end
        end
        ST_FEED: begin
          r_rd_pend <= w_rd_issue;
          if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rd_add <= r_rd_ptr[ARAM_ADD_AW-1:0];
          end
          if (r_rd_pend && !w_nxt_pop) begin
            r_nxt_vld <= 1'b1;
            r_nxt_dat <= ARAM_RD_DAT;
            r_nxt_add <= r_rd_add;
          end else if (w_nxt_pop) begin
            r_nxt_vld <= 1'b0;
          end
          if (w_nxt_pop) begin
            r_cur_vld <= 1'b1;
            r_cur_dat <= w_nxt_dat;
            r_cur_add <= w_nxt_add;
            r_k       <= '0;
          end else if (w_cur_done) begin
            r_cur_vld <= 1'b0;
          end else if (w_accept) begin
            r_k <= r_k + 1'b1;
          end
          if (w_last_beat) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eeg_pea_eng_feed.sv
// ============================================================================
// Module  : tb_eeg_pea_eng_feed
// Brief   : Randomized self-checking bench for eeg_pea_eng_feed against a
//           beat-list reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eeg_pea_eng_feed;

  localparam int AW = 10;
  localparam int AD = 8;
  localparam int WD = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          IS_IDLE;
  logic          CFG_START;
  logic [AW-1:0] CFG_ACT_BEG;
  logic [AW-1:0] CFG_ACT_END;
  logic [CW-1:0] CFG_CONV_WEI;
  logic          WEI_WR_EN;
  logic [CW-1:0] WEI_WR_IDX;
  logic [WD-1:0] WEI_WR_DAT;
  logic          ARAM_RD_EN;
  logic [AW-1:0] ARAM_RD_ADD;
  logic [AD-1:0] ram_q;
  logic          DIN_VLD;
  logic          DIN_RDY;
  logic          ACT_LST;
  logic          WEI_LST;
  logic [AD-1:0] ACT_DAT;
  logic [AW-1:0] ACT_ADD;
  logic [WD-1:0] WEI_DAT;
  logic [CW-1:0] WEI_IDX;

  always #5 clk = ~clk;

  eeg_pea_eng_feed #(
    .DATA_ACT_DW(AD), .DATA_WEI_DW(WD), .ARAM_ADD_AW(AW), .CONV_WEI_DW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .IS_IDLE(IS_IDLE), .CFG_START(CFG_START),
    .CFG_ACT_BEG(CFG_ACT_BEG), .CFG_ACT_END(CFG_ACT_END), .CFG_CONV_WEI(CFG_CONV_WEI),
    .WEI_WR_EN(WEI_WR_EN), .WEI_WR_IDX(WEI_WR_IDX), .WEI_WR_DAT(WEI_WR_DAT),
    .ARAM_RD_EN(ARAM_RD_EN), .ARAM_RD_ADD(ARAM_RD_ADD), .ARAM_RD_DAT(ram_q),
    .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY), .ACT_LST(ACT_LST), .WEI_LST(WEI_LST),
    .ACT_DAT(ACT_DAT), .ACT_ADD(ACT_ADD), .WEI_DAT(WEI_DAT), .WEI_IDX(WEI_IDX)
  );

  // Activation RAM with one-cycle read latency
  logic [AD-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (ARAM_RD_EN) ram_q <= ram[ARAM_RD_ADD];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] add;
    logic [AD-1:0] dat;
    logic [WD-1:0] w;
    logic [CW-1:0] idx;
    logic          wl;
    logic          al;
  } beat_t;

  logic [WD-1:0] wm [0:(1<<CW)-1];
  beat_t exq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_wei(input int idx, input logic [WD-1:0] val);
    tick();
    WEI_WR_EN = 1'b1; WEI_WR_IDX = CW'(idx); WEI_WR_DAT = val;
    wm[idx] = val;
    tick();
    WEI_WR_EN = 1'b0;
  endtask

  function automatic logic rdy_of(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return logic'(cyc % 2 == 1);
    return logic'($urandom_range(0, 1));
  endfunction

  // inj: 0 none, 1 weight write mid-run, 2 start mid-run, 3 reset after 4 beats
  task automatic run(input int beg, input int en, input int wei, input int mode, input int inj);
    int  n, first, last, acc, exp_rd;
    logic prev_rd;
    bit  done;
    bit  ok;
    beat_t b;
    ok = (wei != 0) && (beg <= en);
    n = en - beg + 1;
    exq.delete();
    if (ok) begin
      for (int a = beg; a <= en; a++)
        for (int k = 0; k < wei; k++) begin
          b.add = AW'(a); b.dat = ram[a]; b.w = wm[k]; b.idx = CW'(k);
          b.wl = (k == wei - 1); b.al = (a == en);
          exq.push_back(b);
        end
    end
    first = -1; last = -1; acc = 0; exp_rd = beg; prev_rd = 1'b0; done = 0;
    tick();
    CFG_START = 1'b1; CFG_ACT_BEG = AW'(beg); CFG_ACT_END = AW'(en);
    CFG_CONV_WEI = CW'(wei); DIN_RDY = rdy_of(mode, 0);
    #1;
    check("c0_vld", DIN_VLD, 0);
    check("c0_rd", ARAM_RD_EN, 0);
    if (!ok) begin
      repeat (5) begin
        tick(); CFG_START = 1'b0; #1;
        check("inv_idle", IS_IDLE, 1);
        check("inv_rd", ARAM_RD_EN, 0);
        check("inv_vld", DIN_VLD, 0);
      end
      return;
    end
    for (int cyc = 1; cyc < 2000 && !done; cyc++) begin
      tick();
      CFG_START = 1'b0; WEI_WR_EN = 1'b0; DIN_RDY = rdy_of(mode, cyc);
      if (inj == 1 && cyc == 4) begin
        WEI_WR_EN = 1'b1; WEI_WR_IDX = '0; WEI_WR_DAT = ~wm[0];
      end
      if (inj == 2 && cyc == 5) begin
        CFG_START = 1'b1; CFG_ACT_BEG = '0; CFG_ACT_END = '0; CFG_CONV_WEI = 3'd1;
      end
      if (inj == 3 && acc == 4) begin
        rst_n = 1'b0;
        #1;
        check("rst_idle", IS_IDLE, 1);
        check("rst_outs", {ARAM_RD_EN, ARAM_RD_ADD, DIN_VLD, ACT_LST, WEI_LST,
                           ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < (1 << CW); i++) wm[i] = '0;
        exq.delete();
        return;
      end
      #1;
      check("one_rd", ARAM_RD_EN & prev_rd, 0);
      prev_rd = ARAM_RD_EN;
      if (ARAM_RD_EN) begin
        check("rd_add", ARAM_RD_ADD, exp_rd);
        exp_rd++;
      end
      if (DIN_VLD) begin
        if (first < 0) first = cyc;
        if (exq.size() == 0) begin
          check("extra_beat", DIN_VLD, 0);
        end else begin
          b = exq[0];
          check("act_add", ACT_ADD, b.add);
          check("act_dat", ACT_DAT, b.dat);
          check("wei_dat", WEI_DAT, b.w);
          check("wei_idx", WEI_IDX, b.idx);
          check("lst", {ACT_LST, WEI_LST}, {b.al, b.wl});
          if (DIN_RDY) begin
            void'(exq.pop_front());
            acc++;
            last = cyc;
            if (exq.size() == 0) done = 1;
          end
        end
      end
    end
    check("beats_left", exq.size(), 0);
    check("reads", exp_rd, en + 1);
    if (mode == 0 && inj == 0) begin
      check("first_vld", first, 3);
      check("last_beat", last, (wei >= 2) ? (2 + n * wei) : (3 + 2 * (n - 1)));
    end
    tick();
    DIN_RDY = 1'b0;
    #1;
    check("idle_after", IS_IDLE, 1);
    check("vld_after", DIN_VLD, 0);
  endtask

  initial begin
    int beg, len, wei, mode;
    rst_n = 1'b0; CFG_START = 1'b0; CFG_ACT_BEG = '0; CFG_ACT_END = '0;
    CFG_CONV_WEI = '0; WEI_WR_EN = 1'b0; WEI_WR_IDX = '0; WEI_WR_DAT = '0;
    DIN_RDY = 1'b0;
    for (int i = 0; i < (1 << CW); i++) wm[i] = '0;
    for (int a = 0; a < (1 << AW); a++) ram[a] = AD'(a + 10);
    repeat (3) tick();
    check("rst_idle", IS_IDLE, 1);
    check("rst_outs", {ARAM_RD_EN, ARAM_RD_ADD, DIN_VLD, ACT_LST, WEI_LST,
                       ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}, 0);
    rst_n = 1'b1;

    wr_wei(0, 8'd1); wr_wei(1, 8'hFE); wr_wei(2, 8'd3);
    run(4, 6, 3, 0, 0);
    run(4, 6, 3, 1, 0);
    run(0, 3, 1, 0, 0);
    run(1023, 1023, 2, 0, 0);
    run(0, 3, 0, 0, 0);
    run(5, 4, 2, 0, 0);
    run(4, 6, 3, 0, 1);
    run(4, 6, 3, 0, 2);
    run(4, 6, 3, 0, 3);
    run(4, 6, 3, 0, 0);

    for (int a = 0; a < (1 << AW); a++) ram[a] = AD'($urandom);
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < (1 << CW); i++)
        if ($urandom_range(0, 1) == 1) wr_wei(i, WD'($urandom));
      wei  = $urandom_range(1, 7);
      len  = $urandom_range(0, 5);
      beg  = (it % 5 == 0) ? (1023 - len) : $urandom_range(0, 1000);
      mode = $urandom_range(0, 2);
      run(beg, beg + len, wei, mode, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
